// File: rtl/sobel_gray.sv
// 3x3 Sobel edge detector for sop/eop/vld grayscale streams with an internal two-line buffer.
// Optional macro SOBEL_BORDER_ZERO_EN forces outputs for input row<2 or col<2 to zero.
module sobel_gray #(
  parameter int DW    = 8,
  parameter int IMG_W = 640
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic          din_vld,
  input  logic [DW+2:0] thresh,
  output logic [DW+2:0] dout_mag,
  output logic          dout,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          dout_vld
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW = DW + 2;
  localparam int MW = DW + 3;

  // ---------------------------------------------------------------------------
  // Position counters; a sop pixel is always (0,0) regardless of history
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_reg;
  logic [CW-1:0] col_cur;
  logic [15:0]   row_reg;
  logic [15:0]   row_cur;

  always_comb begin
    col_cur = din_sop ? '0 : col_reg;
    row_cur = din_sop ? '0 : row_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (din_vld) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_reg <= '0;
        row_reg <= row_cur + 16'd1;
      end else begin
        col_reg <= col_cur + CW'(1);
        row_reg <= row_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control pipe: valid/sop/eop travel unconditionally, bit 4 is the output
  // ---------------------------------------------------------------------------
  logic [4:0] vld_sr;
  logic [4:0] sop_sr;
  logic [4:0] eop_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      sop_sr <= '0;
      eop_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[3:0], din_vld};
      sop_sr <= {sop_sr[3:0], din_vld & din_sop};
      eop_sr <= {eop_sr[3:0], din_vld & din_eop};
    end
  end

  assign dout_vld = vld_sr[4];
  assign dout_sop = sop_sr[4];
  assign dout_eop = eop_sr[4];

  // ---------------------------------------------------------------------------
  // S0: line buffer. RAM0 holds row-1, RAM1 holds row-2 (read-before-write)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] ram0 [IMG_W];
  logic [DW-1:0] ram1 [IMG_W];

  always_ff @(posedge clk) begin
    if (din_vld) begin
      ram0[col_cur] <= din;
      ram1[col_cur] <= ram0[col_cur];
    end
  end

  logic [DW-1:0] tap [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) tap[i] <= '0;
    end else if (din_vld) begin
      tap[0] <= ram1[col_cur];
      tap[1] <= ram0[col_cur];
      tap[2] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: 3x3 window, row 0 oldest line, column 0 newest pixel
  // ---------------------------------------------------------------------------
  logic [DW-1:0] win [3][3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else if (vld_sr[0]) begin
      for (int r = 0; r < 3; r++) begin
        win[r][2] <= win[r][1];
        win[r][1] <= win[r][0];
        win[r][0] <= tap[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: weighted row/column sums
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sum_a_next, sum_b_next, sum_c_next, sum_d_next;
  logic [SW-1:0] sum_a_reg, sum_b_reg, sum_c_reg, sum_d_reg;

  always_comb begin
    sum_a_next = SW'(win[0][0]) + {SW'(win[0][1]), 1'b0} + SW'(win[0][2]);
    sum_b_next = SW'(win[2][0]) + {SW'(win[2][1]), 1'b0} + SW'(win[2][2]);
    sum_c_next = SW'(win[0][0]) + {SW'(win[1][0]), 1'b0} + SW'(win[2][0]);
    sum_d_next = SW'(win[0][2]) + {SW'(win[1][2]), 1'b0} + SW'(win[2][2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_a_reg <= '0;
      sum_b_reg <= '0;
      sum_c_reg <= '0;
      sum_d_reg <= '0;
    end else if (vld_sr[1]) begin
      sum_a_reg <= sum_a_next;
      sum_b_reg <= sum_b_next;
      sum_c_reg <= sum_c_next;
      sum_d_reg <= sum_d_next;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: absolute differences by compare-and-subtract
  // ---------------------------------------------------------------------------
  logic [SW-1:0] gx_reg, gy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_reg <= '0;
      gy_reg <= '0;
    end else if (vld_sr[2]) begin
      gx_reg <= (sum_a_reg >= sum_b_reg) ? (sum_a_reg - sum_b_reg) : (sum_b_reg - sum_a_reg);
      gy_reg <= (sum_c_reg >= sum_d_reg) ? (sum_c_reg - sum_d_reg) : (sum_d_reg - sum_c_reg);
    end
  end

  // ---------------------------------------------------------------------------
  // S4: magnitude and live threshold compare
  // ---------------------------------------------------------------------------
  logic [MW-1:0] mag_next;
  logic          border_zero;

`ifdef SOBEL_BORDER_ZERO_EN
  // Border flag rides beside valid so it lines up with the S4 capture
  logic [3:0] border_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      border_sr <= '0;
    end else begin
      border_sr <= {border_sr[2:0],
                    din_vld & ((row_cur < 16'd2) || (col_cur < CW'(2)))};
    end
  end

  assign border_zero = border_sr[3];
`else
  assign border_zero = 1'b0;
`endif

  always_comb begin
    mag_next = MW'(gx_reg) + MW'(gy_reg);
    if (border_zero) mag_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_mag <= '0;
      dout     <= 1'b0;
    end else if (vld_sr[3]) begin
      dout_mag <= mag_next;
      dout     <= border_zero ? 1'b0 : (mag_next >= thresh);
    end
  end

endmodule

// File: tb/tb_sobel_gray.sv
// Scoreboard bench for sobel_gray: directed frames on an 8x6 image, hand-derived expectations.
// Honours SOBEL_BORDER_ZERO_EN when the design is built with it.
module tb_sobel_gray;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int MW    = DW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_sop = 1'b0;
  logic          din_eop = 1'b0;
  logic          din_vld = 1'b0;
  logic [MW-1:0] thresh = '0;
  logic [MW-1:0] dout_mag;
  logic          dout;
  logic          dout_sop;
  logic          dout_eop;
  logic          dout_vld;

  sobel_gray #(.DW(DW), .IMG_W(IMG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_vld  (din_vld),
    .thresh   (thresh),
    .dout_mag (dout_mag),
    .dout     (dout),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout_vld (dout_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit chk;
    int mag;
    bit edg;
    bit sop;
    bit eop;
    int r;
    int c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  // Pixel patterns: 0 flat, 1 rising vertical edge, 2 rising horizontal edge,
  // 3 falling horizontal edge, 4 falling vertical edge
  function automatic int pix(int pat, int r, int c);
    case (pat)
      0:       return 100;
      1:       return (c < 4) ? 0 : 255;
      2:       return (r < 3) ? 0 : 200;
      3:       return (r < 3) ? 200 : 0;
      default: return (c < 4) ? 255 : 0;
    endcase
  endfunction

  // Hand-derived magnitudes for outputs whose window lies inside the current frame
  function automatic int exp_mag(int pat, int r, int c);
    case (pat)
      0:       return 0;
      1, 4:    return (c == 4 || c == 5) ? 1020 : 0;
      default: return (r == 3 || r == 4) ? 800 : 0;
    endcase
  endfunction

  // Monitor: in reset every output must be 0; otherwise pop one entry per dout_vld
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (dout_vld || dout_sop || dout_eop || dout || dout_mag != '0) begin
        errors++;
        $display("FAIL reset_outputs vld=%0b sop=%0b eop=%0b dout=%0b mag=%0d required all 0",
                 dout_vld, dout_sop, dout_eop, dout, dout_mag);
      end
      q.delete();
    end else if (dout_vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld at cycle %0d with empty scoreboard", cyc);
      end else begin
        e = q.pop_front();
        n_out++;
        // sampled at edge n, presented after edge n+4: the 5th clock from input
        checks += 2;
        if (cyc != e.cyc + 4) begin
          errors++;
          $display("FAIL latency (%0d,%0d) got cycle %0d required %0d", e.r, e.c, cyc, e.cyc + 4);
        end
        if (dout_sop != e.sop || dout_eop != e.eop) begin
          errors++;
          $display("FAIL sop_eop (%0d,%0d) got %0b%0b required %0b%0b",
                   e.r, e.c, dout_sop, dout_eop, e.sop, e.eop);
        end
        if (e.chk) begin
          checks += 2;
          if (int'(dout_mag) != e.mag) begin
            errors++;
            $display("FAIL mag (%0d,%0d) got %0d required %0d", e.r, e.c, dout_mag, e.mag);
          end
          if (dout != e.edg) begin
            errors++;
            $display("FAIL edge (%0d,%0d) got %0b required %0b", e.r, e.c, dout, e.edg);
          end
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame (or its first stop_at pixels); full=1 checks every position
  task automatic send_frame(int pat, int th, int gap, bit full, int stop_at);
    exp_t e;
    int   start_out;
    int   idx;
    thresh    = MW'(th);
    start_out = n_out;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        idx = r * IMG_W + c;
        if (idx == stop_at) return;
        din     = DW'(pix(pat, r, c));
        din_sop = (idx == 0);
        din_eop = (idx == IMG_W * IMG_H - 1);
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc;
        e.r   = r;
        e.c   = c;
        e.sop = (idx == 0);
        e.eop = (idx == IMG_W * IMG_H - 1);
        e.chk = full || (r >= 2 && c >= 2);
        e.mag = exp_mag(pat, r, c);
`ifdef SOBEL_BORDER_ZERO_EN
        if (r < 2 || c < 2) begin
          e.chk = 1'b1;
          e.mag = 0;
        end
`endif
        e.edg = (e.mag >= th) && (e.mag != 0 || th == 0);
`ifdef SOBEL_BORDER_ZERO_EN
        if (r < 2 || c < 2) e.edg = 1'b0;
`endif
        q.push_back(e);
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        idle(gap);
      end
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pattern %0d: %0d outputs missing after timeout", pat, q.size());
    end
    checks++;
    if (n_out - start_out != IMG_W * IMG_H) begin
      errors++;
      $display("FAIL vld_count pattern %0d got %0d required %0d", pat, n_out - start_out, IMG_W * IMG_H);
    end
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    send_frame(0, 1, 0, 1'b0, -1);
    send_frame(0, 1, 0, 1'b1, -1);      // second flat frame: every output is 0
    send_frame(1, 512, 0, 1'b0, -1);    // 1020 at cols 4 and 5
    send_frame(2, 800, 0, 1'b0, -1);    // 800 at rows 3 and 4, threshold equal
    send_frame(3, 801, 0, 1'b0, -1);    // 800 just under threshold
    send_frame(4, 2041, 0, 1'b0, -1);   // threshold above maximum magnitude
    send_frame(1, 512, 2, 1'b0, -1);    // valid pattern 1,0,0,1...
    send_frame(0, 1, 2, 1'b0, -1);
    send_frame(0, 1, 2, 1'b1, -1);

    send_frame(1, 512, 0, 1'b0, 20);    // abandoned by reset at pixel 20
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    send_frame(1, 512, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_gray.md
# sobel_gray

Parametrised 3×3 Sobel edge detector for grayscale pixel streams. It sits between the grayscale converter and the SDRAM write path in the CMOS→SDRAM→VGA pipeline, and uses the same sop/eop/vld stream protocol. It contains its own two-line buffer, so no vendor shift-register IP is needed. Outputs are a gradient magnitude and an edge bit compared against a runtime threshold.

## Interface
- DW, 8, input pixel width in bits
- IMG_W, 640, pixels per line; line-buffer depth; column counter wraps here
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- din  input  DW  grayscale pixel
- din_sop  input  1  first pixel of frame, qualified by din_vld
- din_eop  input  1  last pixel of frame, qualified by din_vld
- din_vld  input  1  pixel valid; gaps allowed anywhere
- thresh  input  DW+3  edge threshold, sampled live at the last stage
- dout_mag  output  DW+3  |Gx|+|Gy|
- dout  output  1  edge flag, dout_mag >= thresh
- dout_sop  output  1  din_sop delayed by the pipeline
- dout_eop  output  1  din_eop delayed by the pipeline
- dout_vld  output  1  din_vld delayed by the pipeline

## Operation
- Counters:
  - col counter ($clog2(IMG_W) bits) and row counter (16 bits) advance on each din_vld.
  - On din_vld && din_sop: col=0, row=0 for that pixel.
  - col wraps IMG_W-1 → 0 with row+1.
  - din_sop mid-frame resynchronises the counters; line-buffer contents are kept.
  - eop has no effect on the counters.
- Line buffer:
  - Two simple dual-port RAMs of depth IMG_W × DW, addressed by col.
  - On din_vld: read both RAMs at col; write din into RAM0 at col; write the RAM0 read data into RAM1 at col (read-before-write).
  - Taps: t2 = din (registered), t1 = RAM0 output (row-1), t0 = RAM1 output (row-2).
- Window: 3×3 register array w[row][col]. Column 0 is the newest tap. It shifts only when its stage valid bit is set.
- Arithmetic, all unsigned with no overflow:
  - Weighted sums, each DW+2 bits:
    - A = w00 + 2·w01 + w02
    - B = w20 + 2·w21 + w22
    - C = w00 + 2·w10 + w20
    - D = w02 + 2·w12 + w22
  - Gx = |A−B|, Gy = |C−D|, each DW+2 bits, computed by compare-and-subtract.
  - dout_mag = Gx + Gy, DW+3 bits, maximum 8·(2^DW−1).
- Output alignment: the output for input pixel (r,c) is the window whose newest pixel is (r,c), i.e. centred at (r−1,c−1). One output per input, so the frame size is unchanged.
- Stage enables: each stage registers data only when its own delayed valid bit is 1; otherwise it holds.

## Timing
- Fixed latency of 5 clk from input to output, independent of gaps:
  - S0: RAM read/write, din register
  - S1: window shift
  - S2: weighted sums
  - S3: abs
  - S4: magnitude and threshold compare, all registered
- din_vld/sop/eop travel a 5-bit shift register. dout_vld/sop/eop are its bit 4 and are unconditional (no enable).
- dout and dout_mag hold their last value while dout_vld=0.
- Reset:
  - All outputs, counters, window and pipeline registers are cleared to 0 immediately.
  - RAM contents are not cleared.
  - No dout_vld until 5 clk after the first post-reset din_vld.
- Reset mid-frame: the partial frame is discarded. Output resumes cleanly at the next din_sop.
- thresh changing mid-frame takes effect on the very next S4 capture.
- Simultaneous din_sop and din_eop (1-pixel frame): both propagate, and the counters reset.

## Configuration
- SOBEL_BORDER_ZERO_EN defined: outputs whose input position has row<2 or col<2 are forced to dout_mag=0, dout=0. The row/col flag is piped alongside valid.
- Not defined: border outputs are computed from whatever the buffers hold (previous line or previous frame data). The flag logic is absent.

## Test plan
- Flat frame (IMG_W=8, 8×6, all din=100, thresh=1):
  - dout_mag=0, dout=0 for all 48 outputs.
  - dout_vld count = 48.
- Vertical step (cols 0-3 = 0, cols 4-7 = 255, thresh=512):
  - For rows ≥2, outputs at col 4 and col 5 (windows centred at cols 3 and 4) give dout_mag=1020 and dout=1.
  - Other interior columns give dout_mag=0.
- Same frames as above with din_vld toggling 1,0,0,1…:
  - Identical dout_mag sequence.
  - Each dout_vld occurs exactly 5 clk after its din_vld.
- Single frame: dout_sop occurs 5 clk after din_sop; dout_eop occurs 5 clk after din_eop. With thresh=2041 (DW=8), dout=0 everywhere.
- With SOBEL_BORDER_ZERO_EN, random data: every output with row<2 or col<2 has dout_mag=0. Interior outputs match the reference model.
- rst_n low for 3 clk at pixel 20, then a new frame:
  - All outputs are 0 during reset.
  - The first post-reset dout_vld comes 5 clk after the first din_vld.
  - The new frame matches the model, comparing from row 2.
